range_window_tracker: RTL and testbench
=======================================

// Module: range_window_tracker
// PURPOSE
//   Multi-channel, parametrised windowed range tracker. Accepts CH packed W-bit samples per
//   beat over a valid/ready handshake and accumulates per-channel min, max and span (max-min)
//   over WIN beats or until an early flush. It then presents one result beat over an output
//   valid/ready handshake. Successor to the fixed-width range blocks; sits between sample
//   sources and status/statistics logic.
// PARAMETERS
//   W     4              sample width per channel (>=1)
//   CH    3              channel count (>=1); channel c occupies bits [c*W +: W]
//   WIN   8              beats per window (>=2)
//   CW    $clog2(WIN)+1  derived; width of beat counter and out_count (do not override)
// PORTS
//   clk        in   1      clock, rising edge
//   rst        in   1      reset, asynchronous, active-high
//   in_valid   in   1      input beat valid
//   in_ready   out  1      block can accept a beat
//   in_data    in   CH*W   packed unsigned samples
//   flush      in   1      close current window early (single-cycle pulse)
//   out_valid  out  1      result beat valid
//   out_ready  in   1      consumer accepts result
//   out_min    out  CH*W   per-channel minimum over window
//   out_max    out  CH*W   per-channel maximum over window
//   out_span   out  CH*W   per-channel out_max - out_min (never negative, W bits)
//   out_count  out  CW     number of beats in reported window (1..WIN)
// BEHAVIOUR
//   Reset (async assert, sync release): state=ACCUM, count=0. in_ready=0 while rst is high, 1 after.
//     out_valid=0. out_min/out_max/out_span/out_count=0. Running min/max regs=0.
//   States: ACCUM, HOLD. in_ready = (state==ACCUM). accept = in_valid & in_ready.
//   ACCUM, accept, count==0: min[c]=max[c]=sample[c] for all c; count=1.
//   ACCUM, accept, count>0: min[c]=min(min[c],s[c]), max[c]=max(max[c],s[c]) unsigned; count++.
//   Window close: at an accept that makes count==WIN, or at flush when the post-update count is >0.
//     On close: out_* regs load the updated values, including this beat's sample.
//     out_count=post-update count. out_valid=1. State->HOLD. count=0.
//   Flush with accept in the same cycle: the sample is included, then the window closes.
//   Flush with count==0 and no accept: ignored, no result beat.
//   Flush in HOLD: ignored. It does not queue.
//   HOLD: out_* stable while out_valid=1 & !out_ready.
//     On out_ready: out_valid=0 next cycle, state->ACCUM.
//     out_* keep their last values after the handshake; only out_valid drops.
//   Latency: a result is visible the cycle after the closing accept or flush.
//     Zero-bubble is not required: in_ready=0 for exactly the HOLD cycles.
//   Counter never exceeds WIN; no wrap. out_span computed at close from updated min/max.
//   Reset mid-window or in HOLD: partial window discarded, no output beat, outputs back to reset values.
//   Channels independent; all share one count and one handshake.
// TESTING (W=4, CH=3, WIN=4)
//   1. rst pulse mid-cycle -> out_valid=0, all out_*=0, in_ready=0 during rst, 1 the cycle after release.
//   2. Ch0 samples 5,2,9,7, out_ready=1 -> one beat: min0=2, max0=9, span0=7, out_count=4.
//      in_ready=0 for one cycle.
//   3. Samples {F,0,8},{0,F,8} then flush alone -> out_count=2.
//      Ch0 min0/max0/span0=0/F/F, ch1 0/F/F, ch2 8/8/0.
//   4. Flush with count=0 and no beat -> no out_valid.
//      Flush together with the 3rd beat (values 1,3,2) -> out_count=3, min0=1, max0=3.
//   5. out_ready=0 for 5 cycles after close -> out_* stable, in_ready=0, in_valid beats not taken.
//      out_ready=1 -> next window starts fresh: first sample sets both min and max.
//   6. rst asserted after 3 of 4 beats -> no result.
//      A full window after release reports only post-reset samples.

Source files
------------

// File: rtl/range_window_tracker_if.sv
// Handshake bundle for range_window_tracker.
// master = sample source / result sink, slave = tracker.
interface range_window_tracker_if #(
  parameter int W   = 4,
  parameter int CH  = 3,
  parameter int WIN = 8,
  localparam int CW = $clog2(WIN) + 1
);
  logic            in_valid;
  logic            in_ready;
  logic [CH*W-1:0] in_data;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [CH*W-1:0] out_min;
  logic [CH*W-1:0] out_max;
  logic [CH*W-1:0] out_span;
  logic [CW-1:0]   out_count;

  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_min, out_max,
    input  out_span, out_count
  );

  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_min, out_max,
    output out_span, out_count
  );
endinterface

// File: rtl/range_window_tracker.sv
// Per-channel windowed min/max/span tracker.
// Closes on WIN beats or flush, then holds one result beat.
module range_window_tracker #(
  parameter int W   = 4,
  parameter int CH  = 3,
  parameter int WIN = 8,
  localparam int CW = $clog2(WIN) + 1
) (
  input logic                   clk,
  input logic                   rst,
  range_window_tracker_if.slave bus
);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t          state;
  state_t          state_nx;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_upd;
  logic [CH*W-1:0] mn;
  logic [CH*W-1:0] mx;
  logic [CH*W-1:0] mn_upd;
  logic [CH*W-1:0] mx_upd;
  logic [CH*W-1:0] span_upd;
  logic [CH*W-1:0] omin;
  logic [CH*W-1:0] omax;
  logic [CH*W-1:0] ospan;
  logic [CW-1:0]   ocount;
  logic            ovalid;
  logic            accept;
  logic            close;

  assign bus.in_ready  = ~rst & (state == ACCUM);
  assign accept        = bus.in_valid & bus.in_ready;
  assign cnt_upd       = cnt + CW'(accept);

  assign bus.out_valid = ovalid;
  assign bus.out_min   = omin;
  assign bus.out_max   = omax;
  assign bus.out_span  = ospan;
  assign bus.out_count = ocount;

  // Fold this beat into the running extremes; first beat seeds them.
  always_comb begin
    mn_upd   = mn;
    mx_upd   = mx;
    span_upd = '0;
    for (int c = 0; c < CH; c++) begin
      if (accept) begin
        if (cnt == '0 || bus.in_data[c*W +: W] < mn[c*W +: W])
          mn_upd[c*W +: W] = bus.in_data[c*W +: W];
        if (cnt == '0 || bus.in_data[c*W +: W] > mx[c*W +: W])
          mx_upd[c*W +: W] = bus.in_data[c*W +: W];
      end
      span_upd[c*W +: W] = mx_upd[c*W +: W] - mn_upd[c*W +: W];
    end
  end

  // Next state: close the window into HOLD, release on consumer accept.
  always_comb begin
    state_nx = state;
    close    = 1'b0;
    unique case (state)
      ACCUM: begin
        if ((accept && cnt_upd == CW'(WIN)) ||
            (bus.flush && cnt_upd != '0)) begin
          close    = 1'b1;
          state_nx = HOLD;
        end
      end
      HOLD: begin
        if (bus.out_ready)
          state_nx = ACCUM;
      end
      default: state_nx = ACCUM;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= ACCUM;
    else
      state <= state_nx;
  end

  // Running extremes, beat counter and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      mn     <= '0;
      mx     <= '0;
      omin   <= '0;
      omax   <= '0;
      ospan  <= '0;
      ocount <= '0;
      ovalid <= 1'b0;
    end else begin
      if (accept) begin
        mn <= mn_upd;
        mx <= mx_upd;
      end
      cnt <= close ? '0 : cnt_upd;
      if (close) begin
        omin   <= mn_upd;
        omax   <= mx_upd;
        ospan  <= span_upd;
        ocount <= cnt_upd;
        ovalid <= 1'b1;
      end else if (state == HOLD && bus.out_ready) begin
        ovalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_range_window_tracker.sv
// Directed bench for range_window_tracker (W=4, CH=3, WIN=4).
// Each task drives one scenario and checks inline.
module tb_range_window_tracker;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  range_window_tracker_if #(.W(4), .CH(3), .WIN(4)) bus ();

  range_window_tracker #(.W(4), .CH(3), .WIN(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [11:0] d, input logic f);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.flush    = f;
    tick();
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    beat(12'h0A5, 1'b0);
    #4;
    rst = 1'b1;
    #1;
    tests++;
    if (bus.in_ready !== 1'b0) begin
      fails++;
      $display("FAIL rst_in_ready got %b exp 0", bus.in_ready);
    end
    tests++;
    if (bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_out_valid got %b exp 0", bus.out_valid);
    end
    tests++;
    if ({bus.out_min, bus.out_max, bus.out_span} !== 36'h0 ||
        bus.out_count !== 3'd0) begin
      fails++;
      $display("FAIL rst_outs got %h %h %h %0d exp 0",
               bus.out_min, bus.out_max, bus.out_span, bus.out_count);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    tests++;
    if (bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL rst_release_ready got %b exp 1", bus.in_ready);
    end
  endtask

  task automatic test_basic();
    bus.out_ready = 1'b1;
    beat(12'h005, 1'b0);
    beat(12'h002, 1'b0);
    beat(12'h009, 1'b0);
    tests++;
    if (bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL basic_early got %b exp 0", bus.out_valid);
    end
    beat(12'h007, 1'b0);
    tests++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      fails++;
      $display("FAIL basic_close got v=%b r=%b exp v=1 r=0",
               bus.out_valid, bus.in_ready);
    end
    tests++;
    if (bus.out_min !== 12'h002 || bus.out_max !== 12'h009 ||
        bus.out_span !== 12'h007 || bus.out_count !== 3'd4) begin
      fails++;
      $display("FAIL basic_result got %h %h %h %0d exp 002 009 007 4",
               bus.out_min, bus.out_max, bus.out_span, bus.out_count);
    end
    tick();
    tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL basic_release got v=%b r=%b exp v=0 r=1",
               bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_flush_alone();
    bus.out_ready = 1'b1;
    beat(12'h80F, 1'b0);
    beat(12'h8F0, 1'b0);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    tests++;
    if (bus.out_valid !== 1'b1 || bus.out_count !== 3'd2) begin
      fails++;
      $display("FAIL flush_close got v=%b n=%0d exp v=1 n=2",
               bus.out_valid, bus.out_count);
    end
    tests++;
    if (bus.out_min !== 12'h800 || bus.out_max !== 12'h8FF ||
        bus.out_span !== 12'h0FF) begin
      fails++;
      $display("FAIL flush_result got %h %h %h exp 800 8ff 0ff",
               bus.out_min, bus.out_max, bus.out_span);
    end
    tick();
  endtask

  task automatic test_flush_empty();
    bus.out_ready = 1'b1;
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL empty_flush got v=%b r=%b exp v=0 r=1",
               bus.out_valid, bus.in_ready);
    end
    beat(12'h001, 1'b0);
    beat(12'h003, 1'b0);
    beat(12'h002, 1'b1);
    tests++;
    if (bus.out_valid !== 1'b1 || bus.out_count !== 3'd3) begin
      fails++;
      $display("FAIL flush_beat got v=%b n=%0d exp v=1 n=3",
               bus.out_valid, bus.out_count);
    end
    tests++;
    if (bus.out_min !== 12'h001 || bus.out_max !== 12'h003 ||
        bus.out_span !== 12'h002) begin
      fails++;
      $display("FAIL flush_beat_res got %h %h %h exp 001 003 002",
               bus.out_min, bus.out_max, bus.out_span);
    end
    tick();
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    beat(12'h006, 1'b0);
    beat(12'h00A, 1'b0);
    beat(12'h003, 1'b0);
    beat(12'h008, 1'b0);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 12'h000;
      bus.flush    = (i == 2);
      tick();
      tests++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
          bus.out_min !== 12'h003 || bus.out_max !== 12'h00A ||
          bus.out_span !== 12'h007 || bus.out_count !== 3'd4) begin
        fails++;
        $display("FAIL hold_%0d got v=%b r=%b %h %h %h %0d exp 1 0 003 00a 007 4",
                 i, bus.out_valid, bus.in_ready, bus.out_min,
                 bus.out_max, bus.out_span, bus.out_count);
      end
    end
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tests++;
    if (bus.out_valid !== 1'b0 || bus.out_min !== 12'h003) begin
      fails++;
      $display("FAIL hold_release got v=%b min=%h exp v=0 min=003",
               bus.out_valid, bus.out_min);
    end
    beat(12'h009, 1'b0);
    beat(12'h00B, 1'b0);
    beat(12'h009, 1'b0);
    beat(12'h009, 1'b0);
    tests++;
    if (bus.out_valid !== 1'b1 || bus.out_min !== 12'h009 ||
        bus.out_max !== 12'h00B || bus.out_span !== 12'h002 ||
        bus.out_count !== 3'd4) begin
      fails++;
      $display("FAIL fresh_window got v=%b %h %h %h %0d exp 1 009 00b 002 4",
               bus.out_valid, bus.out_min, bus.out_max,
               bus.out_span, bus.out_count);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b1;
    beat(12'h011, 1'b0);
    beat(12'h011, 1'b0);
    beat(12'h011, 1'b0);
    rst = 1'b1;
    tick();
    tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 ||
        bus.out_min !== 12'h000 || bus.out_count !== 3'd0) begin
      fails++;
      $display("FAIL midrst got v=%b r=%b min=%h n=%0d exp 0 0 000 0",
               bus.out_valid, bus.in_ready, bus.out_min, bus.out_count);
    end
    rst = 1'b0;
    tick();
    beat(12'h007, 1'b0);
    tests++;
    if (bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL midrst_stale got v=%b exp 0", bus.out_valid);
    end
    beat(12'h008, 1'b0);
    beat(12'h009, 1'b0);
    beat(12'h00A, 1'b0);
    tests++;
    if (bus.out_valid !== 1'b1 || bus.out_min !== 12'h007 ||
        bus.out_max !== 12'h00A || bus.out_span !== 12'h003 ||
        bus.out_count !== 3'd4) begin
      fails++;
      $display("FAIL midrst_window got v=%b %h %h %h %0d exp 1 007 00a 003 4",
               bus.out_valid, bus.out_min, bus.out_max,
               bus.out_span, bus.out_count);
    end
    tick();
  endtask

  initial begin
    tests         = 0;
    fails         = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_flush_alone();
    test_flush_empty();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
